// File: rtl/spi_master.sv
// Mode-0 SPI master for the crossover coefficient/control link.
// Sends CMD_NBITS+DATA_NBITS bits MSB first and returns the low DATA_NBITS received.
module spi_master #(
    parameter int CMD_NBITS   = 8,
    parameter int DATA_NBITS  = 32,
    parameter int HALF_PERIOD = 8,
    parameter int LEAD_CYCLES = 8,
    parameter int GAP_CYCLES  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_start,
    input  logic [CMD_NBITS-1:0]  i_cmd,
    input  logic [DATA_NBITS-1:0] i_data,
    input  logic                  i_miso,
    output logic                  o_sclk,
    output logic                  o_ssn,
    output logic                  o_mosi,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DATA_NBITS-1:0] o_rx_data
);

    localparam int N       = CMD_NBITS + DATA_NBITS;
    localparam int DIV_HL  = (HALF_PERIOD > LEAD_CYCLES) ? HALF_PERIOD : LEAD_CYCLES;
    localparam int DIV_MAX = (DIV_HL > GAP_CYCLES) ? DIV_HL : GAP_CYCLES;
    localparam int DW      = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
    localparam int BW      = $clog2(N);

    localparam logic [DW-1:0] H_LAST = DW'(HALF_PERIOD - 1);
    localparam logic [DW-1:0] L_LAST = DW'(LEAD_CYCLES - 1);
    localparam logic [DW-1:0] G_LAST = DW'(GAP_CYCLES - 1);
    localparam logic [BW-1:0] B_LAST = BW'(N - 1);

    generate
        if (HALF_PERIOD < 8 || LEAD_CYCLES < 4 || GAP_CYCLES < 4) begin : g_bad_param
            $error("spi_master: HALF_PERIOD>=8, LEAD_CYCLES>=4, GAP_CYCLES>=4 required");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_HIGH,
        S_LOW,
        S_TAIL,
        S_GAP
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [DW-1:0]         r_div, w_div_nxt, w_limit;
    logic [BW-1:0]         r_bit, w_bit_nxt;
    logic [N-2:0]          r_tx_sr, w_tx_nxt;
    logic [DATA_NBITS-1:0] r_rx_sr, w_rx_nxt;
    logic [DATA_NBITS-1:0] r_rx_data, w_rx_data_nxt;
    logic                  r_sclk, w_sclk_nxt;
    logic                  r_ssn, w_ssn_nxt;
    logic                  r_mosi, w_mosi_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_done, w_done_nxt;
    logic                  r_rst_meta, r_rstn_sync;
    logic                  r_miso_meta, r_miso_sync;
    logic [N-1:0]          w_frame;
    logic                  w_last;

    // Reset asserts asynchronously but is released on a clock edge.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_rst_meta  <= 1'b0;
            r_rstn_sync <= 1'b0;
        end else begin
            r_rst_meta  <= 1'b1;
            r_rstn_sync <= r_rst_meta;
        end
    end

    always_ff @(posedge i_clk or negedge r_rstn_sync) begin
        if (!r_rstn_sync) begin
            r_miso_meta <= 1'b0;
            r_miso_sync <= 1'b0;
        end else begin
            r_miso_meta <= i_miso;
            r_miso_sync <= r_miso_meta;
        end
    end

    assign w_frame = {i_cmd, i_data};

    always_comb begin
        unique case (r_state)
            S_LEAD, S_TAIL: w_limit = L_LAST;
            S_HIGH, S_LOW:  w_limit = H_LAST;
            default:        w_limit = G_LAST;
        endcase
    end

    assign w_last = (r_div == w_limit);

    always_comb begin
        w_state_nxt   = r_state;
        w_div_nxt     = r_div;
        w_bit_nxt     = r_bit;
        w_tx_nxt      = r_tx_sr;
        w_rx_nxt      = r_rx_sr;
        w_rx_data_nxt = r_rx_data;
        w_sclk_nxt    = r_sclk;
        w_ssn_nxt     = r_ssn;
        w_mosi_nxt    = r_mosi;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;

        if (r_state != S_IDLE) begin
            w_div_nxt = w_last ? '0 : r_div + 1'b1;
        end

        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    // First bit goes straight to MOSI; tx_sr keeps the rest.
                    w_tx_nxt    = w_frame[N-2:0];
                    w_mosi_nxt  = w_frame[N-1];
                    w_ssn_nxt   = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_div_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = S_LEAD;
                end
            end
            S_LEAD: begin
                if (w_last) begin
                    w_sclk_nxt  = 1'b1;
                    w_state_nxt = S_HIGH;
                end
            end
            S_HIGH: begin
                if (w_last) begin
                    w_sclk_nxt = 1'b0;
                    w_rx_nxt   = {r_rx_sr[DATA_NBITS-2:0], r_miso_sync};
                    if (r_bit == B_LAST) begin
                        w_state_nxt = S_TAIL;
                    end else begin
                        w_mosi_nxt  = r_tx_sr[N-2];
                        w_tx_nxt    = {r_tx_sr[N-3:0], 1'b0};
                        w_bit_nxt   = r_bit + 1'b1;
                        w_state_nxt = S_LOW;
                    end
                end
            end
            S_LOW: begin
                if (w_last) begin
                    w_sclk_nxt  = 1'b1;
                    w_state_nxt = S_HIGH;
                end
            end
            S_TAIL: begin
                if (w_last) begin
                    w_ssn_nxt     = 1'b1;
                    w_rx_data_nxt = r_rx_sr;
                    w_done_nxt    = 1'b1;
                    w_state_nxt   = S_GAP;
                end
            end
            S_GAP: begin
                if (w_last) begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge r_rstn_sync) begin
        if (!r_rstn_sync) begin
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_bit     <= '0;
            r_tx_sr   <= '0;
            r_rx_sr   <= '0;
            r_rx_data <= '0;
            r_sclk    <= 1'b0;
            r_ssn     <= 1'b1;
            r_mosi    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_div     <= w_div_nxt;
            r_bit     <= w_bit_nxt;
            r_tx_sr   <= w_tx_nxt;
            r_rx_sr   <= w_rx_nxt;
            r_rx_data <= w_rx_data_nxt;
            r_sclk    <= w_sclk_nxt;
            r_ssn     <= w_ssn_nxt;
            r_mosi    <= w_mosi_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign o_sclk    = r_sclk;
    assign o_ssn     = r_ssn;
    assign o_mosi    = r_mosi;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_rx_data = r_rx_data;

endmodule
